// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - UART transmitter and receiver, each with a FIFO
// The TX line is registered, so the start bit appears one clock after the FSM leaves IDLE.
module uart_fifo #(
   parameter int FREQ_MHZ   = 12,
   parameter int BAUDS      = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_ni,
   output logic                          tx_o,
   input  logic                          rx_i,
   input  logic                          wr_i,
   input  logic [7:0]                    tx_data_i,
   input  logic                          rd_i,
   output logic [7:0]                    rx_data_o,
   output logic                          rx_valid_o,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
   output logic                          tx_full_o,
   output logic                          busy_o,
   output logic                          frame_err_o,
   output logic                          parity_err_o,
   output logic                          overrun_o,
   input  logic                          clr_err_i
);
   localparam int DIV = FREQ_MHZ * 1000000 / BAUDS;
   localparam int CW  = $clog2(DIV + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   // TX FIFO
   logic [7:0]    txf_mem [FIFO_DEPTH];
   logic [AW-1:0] txf_wr_q, txf_rd_q;
   logic [LW-1:0] txf_cnt_q;
   logic          txf_push, txf_pop;
   logic [7:0]    tx_head;

   assign tx_full_o = (txf_cnt_q == DEPTH_L);
   assign txf_push  = wr_i && !tx_full_o;
   assign tx_head   = txf_mem[txf_rd_q];

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         txf_wr_q  <= '0;
         txf_rd_q  <= '0;
         txf_cnt_q <= '0;
      end else begin
         if (txf_push) txf_wr_q <= txf_wr_q + AW'(1);
         if (txf_pop)  txf_rd_q <= txf_rd_q + AW'(1);
         txf_cnt_q <= txf_cnt_q + LW'(txf_push) - LW'(txf_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (txf_push) txf_mem[txf_wr_q] <= tx_data_i & DATA_MASK;
   end

   // TX FSM
   state_e        tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_par_q, tx_par_d;
   logic          tx_q, tx_d;
   logic          tx_bit_end;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_d       = 1'b1;
      txf_pop    = 1'b0;
      tx_bit_end = (tx_cnt_q == DIV_LAST);
      if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
      unique case (tx_state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (txf_cnt_q != '0) begin
               txf_pop    = 1'b1;
               tx_shift_d = tx_head;
               tx_par_d   = (PARITY == 1) ? ~(^tx_head) : ^tx_head;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_d = tx_shift_q[0];
            if (tx_bit_end) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == LAST_BIT) begin
                  tx_bit_d   = '0;
                  tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            tx_d = tx_par_q;
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (tx_bit_end) begin
               if (tx_bit_q != LAST_STOP) begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end else if (txf_cnt_q != '0) begin
                  // back-to-back frames: reload straight from the last stop bit
                  txf_pop    = 1'b1;
                  tx_shift_d = tx_head;
                  tx_par_d   = (PARITY == 1) ? ~(^tx_head) : ^tx_head;
                  tx_bit_d   = '0;
                  tx_state_d = S_START;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (txf_cnt_q != '0) || (tx_state_q != S_IDLE);

   // RX synchroniser; armed only after the line has been seen idle-high
   logic rx_s1_q, rx_s2_q, rx_armed_q;

   state_e        rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_par_exp, rx_done, set_fe, set_pe, set_ov, rx_disarm;

   assign rx_par_exp = (PARITY == 1) ? ~(^rx_shift_q) : ^rx_shift_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      set_fe     = 1'b0;
      set_pe     = 1'b0;
      rx_disarm  = 1'b0;
      if (rx_state_q != S_IDLE) rx_cnt_d = rx_cnt_q + CW'(1);
      unique case (rx_state_q)
         S_IDLE: begin
            if (rx_armed_q && !rx_s2_q) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_shift_d = '0;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d             = '0;
               rx_shift_d[rx_bit_q] = rx_s2_q;
               if (rx_bit_q == LAST_BIT) begin
                  rx_bit_d   = '0;
                  rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               set_pe     = (rx_s2_q != rx_par_exp);
               rx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = S_IDLE;
               if (rx_s2_q) begin
                  rx_done = 1'b1;
               end else begin
                  // break/framing error: wait for the line to return high
                  set_fe    = 1'b1;
                  rx_disarm = 1'b1;
               end
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         rx_s1_q    <= 1'b0;
         rx_s2_q    <= 1'b0;
         rx_armed_q <= 1'b0;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         if (rx_disarm)    rx_armed_q <= 1'b0;
         else if (rx_s2_q) rx_armed_q <= 1'b1;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // RX FIFO, first-word-fall-through
   logic [7:0]    rxf_mem [FIFO_DEPTH];
   logic [AW-1:0] rxf_wr_q, rxf_rd_q;
   logic [LW-1:0] rxf_cnt_q;
   logic          rxf_full, rx_push, rx_pop;

   assign rxf_full   = (rxf_cnt_q == DEPTH_L);
   assign rx_push    = rx_done && !rxf_full;
   assign set_ov     = rx_done && rxf_full;
   assign rx_valid_o = (rxf_cnt_q != '0);
   assign rx_pop     = rd_i && rx_valid_o;
   assign rx_level_o = rxf_cnt_q;
   assign rx_data_o  = rx_valid_o ? rxf_mem[rxf_rd_q] : 8'h00;

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         rxf_wr_q  <= '0;
         rxf_rd_q  <= '0;
         rxf_cnt_q <= '0;
      end else begin
         if (rx_push) rxf_wr_q <= rxf_wr_q + AW'(1);
         if (rx_pop)  rxf_rd_q <= rxf_rd_q + AW'(1);
         rxf_cnt_q <= rxf_cnt_q + LW'(rx_push) - LW'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rxf_mem[rxf_wr_q] <= rx_shift_q;
   end

   // sticky error flags; a new error wins over a simultaneous clear
   logic fe_q, pe_q, ov_q;

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         fe_q <= 1'b0;
         pe_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         fe_q <= (fe_q && !clr_err_i) || set_fe;
         pe_q <= (pe_q && !clr_err_i) || set_pe;
         ov_q <= (ov_q && !clr_err_i) || set_ov;
      end
   end

   assign frame_err_o  = fe_q;
   assign parity_err_o = pe_q;
   assign overrun_o    = ov_q;
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - directed bench for uart_fifo, 8N1 and 8E1 instances at DIV=10
module tb_uart_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_ni;
   logic       tx_o, rx_i, wr_i, rd_i, clr_err_i;
   logic [7:0] tx_data_i, rx_data_o;
   logic       rx_valid_o, tx_full_o, busy_o, fe, pe, ov;
   logic [2:0] rx_level_o;
   logic       loop_en, rx_drv;

   logic       p_tx_o, p_wr_i, p_rd_i, p_clr_err_i;
   logic [7:0] p_tx_data_i, p_rx_data_o;
   logic       p_rx_valid_o, p_tx_full_o, p_busy_o, p_fe, p_pe, p_ov;
   logic [2:0] p_rx_level_o;
   logic       rx_drv_p;

   int checks = 0;
   int errors = 0;
   logic [9:0]  fr;
   logic [10:0] frp;
   logic        seen_full;
   int          n;
   logic [7:0]  got [8];
   int          t_arr [8];

   assign rx_i = loop_en ? tx_o : rx_drv;

   uart_fifo #(.FREQ_MHZ(1), .BAUDS(100000), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .reset_ni(reset_ni), .tx_o(tx_o), .rx_i(rx_i),
      .wr_i(wr_i), .tx_data_i(tx_data_i), .rd_i(rd_i), .rx_data_o(rx_data_o),
      .rx_valid_o(rx_valid_o), .rx_level_o(rx_level_o), .tx_full_o(tx_full_o),
      .busy_o(busy_o), .frame_err_o(fe), .parity_err_o(pe), .overrun_o(ov),
      .clr_err_i(clr_err_i));

   uart_fifo #(.FREQ_MHZ(1), .BAUDS(100000), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_p (
      .clk(clk), .reset_ni(reset_ni), .tx_o(p_tx_o), .rx_i(rx_drv_p),
      .wr_i(p_wr_i), .tx_data_i(p_tx_data_i), .rd_i(p_rd_i), .rx_data_o(p_rx_data_o),
      .rx_valid_o(p_rx_valid_o), .rx_level_o(p_rx_level_o), .tx_full_o(p_tx_full_o),
      .busy_o(p_busy_o), .frame_err_o(p_fe), .parity_err_o(p_pe), .overrun_o(p_ov),
      .clr_err_i(p_clr_err_i));

   task automatic chk(input string tag, input bit ok);
      checks++;
      if (!ok) begin
         errors++;
         $error("FAIL %s", tag);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic drive(input bit to_p, input logic v);
      if (to_p) rx_drv_p = v;
      else      rx_drv   = v;
   endtask

   task automatic send(input bit to_p, input logic [7:0] d, input bit has_par,
                       input logic par, input logic stop);
      drive(to_p, 1'b0);
      cyc(10);
      for (int i = 0; i < 8; i++) begin
         drive(to_p, d[i]);
         cyc(10);
      end
      if (has_par) begin
         drive(to_p, par);
         cyc(10);
      end
      drive(to_p, stop);
      cyc(10);
      drive(to_p, 1'b1);
   endtask

   initial begin
      reset_ni = 1'b0; wr_i = 1'b0; rd_i = 1'b0; clr_err_i = 1'b0; tx_data_i = 8'h00;
      loop_en = 1'b0; rx_drv = 1'b1; rx_drv_p = 1'b1;
      p_wr_i = 1'b0; p_rd_i = 1'b0; p_clr_err_i = 1'b0; p_tx_data_i = 8'h00;
      cyc(3);
      chk("rst_tx", tx_o === 1'b1);
      chk("rst_busy", busy_o === 1'b0);
      chk("rst_valid", rx_valid_o === 1'b0);
      chk("rst_level", rx_level_o === 3'd0);
      chk("rst_full", tx_full_o === 1'b0);
      chk("rst_data", rx_data_o === 8'h00);
      chk("rst_flags", {fe, pe, ov} === 3'b000);
      reset_ni = 1'b1;
      cyc(5);

      loop_en = 1'b1;
      fr = {1'b1, 8'hA5, 1'b0};
      wr_i = 1'b1; tx_data_i = 8'hA5;
      cyc(1);
      wr_i = 1'b0;
      chk("lat_edge1", tx_o === 1'b1);
      cyc(1);
      chk("lat_edge2", tx_o === 1'b1);
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk($sformatf("a5_bit%0d_clk%0d", b, k), tx_o === fr[b]);
         end
      end
      for (int i = 0; i < 30 && !rx_valid_o; i++) cyc(1);
      chk("a5_valid", rx_valid_o === 1'b1);
      chk("a5_data", rx_data_o === 8'hA5);
      chk("a5_level", rx_level_o === 3'd1);
      chk("a5_flags", {fe, pe, ov} === 3'b000);
      chk("a5_busy", busy_o === 1'b0);
      rd_i = 1'b1; cyc(1); rd_i = 1'b0;
      chk("a5_pop_valid", rx_valid_o === 1'b0);
      chk("a5_pop_data", rx_data_o === 8'h00);
      loop_en = 1'b0;
      cyc(5);

      send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
      cyc(2);
      chk("par_err", p_pe === 1'b1);
      chk("par_data", p_rx_data_o === 8'h03);
      chk("par_valid", p_rx_valid_o === 1'b1);
      chk("par_fe", p_fe === 1'b0);
      p_clr_err_i = 1'b1; cyc(1); p_clr_err_i = 1'b0;
      chk("par_clr", p_pe === 1'b0);
      send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      cyc(2);
      chk("par_good_err", p_pe === 1'b0);
      chk("par_good_level", p_rx_level_o === 3'd2);
      p_rd_i = 1'b1; cyc(1);
      chk("par_second", p_rx_data_o === 8'h07);
      cyc(1); p_rd_i = 1'b0;
      chk("par_empty", p_rx_level_o === 3'd0);

      frp = {1'b1, 1'b1, 8'h07, 1'b0};
      p_wr_i = 1'b1; p_tx_data_i = 8'h07;
      cyc(1);
      p_wr_i = 1'b0;
      cyc(1);
      for (int b = 0; b < 11; b++) begin
         cyc(5);
         chk($sformatf("ptx_bit%0d", b), p_tx_o === frp[b]);
         cyc(5);
      end
      cyc(10);

      send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      cyc(2);
      chk("fe_set", fe === 1'b1);
      chk("fe_valid", rx_valid_o === 1'b0);
      chk("fe_level", rx_level_o === 3'd0);
      chk("fe_pe", pe === 1'b0);
      clr_err_i = 1'b1; cyc(1); clr_err_i = 1'b0;
      chk("fe_clr", fe === 1'b0);
      send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      cyc(2);
      chk("after_fe_data", rx_data_o === 8'h5A);
      rd_i = 1'b1; cyc(1); rd_i = 1'b0;

      for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      cyc(2);
      chk("ovr_level", rx_level_o === 3'd4);
      chk("ovr_flag", ov === 1'b1);
      chk("ovr_head", rx_data_o === 8'h01);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovr_pop%0d", i), rx_data_o === 8'(i));
         rd_i = 1'b1; cyc(1); rd_i = 1'b0;
      end
      chk("ovr_drained", rx_valid_o === 1'b0);
      clr_err_i = 1'b1; cyc(1); clr_err_i = 1'b0;
      chk("ovr_clr", ov === 1'b0);

      loop_en = 1'b1;
      seen_full = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_i = 1'b1; tx_data_i = 8'h10 + 8'(i);
         cyc(1);
         if (tx_full_o) seen_full = 1'b1;
      end
      wr_i = 1'b0; tx_data_i = 8'h00;
      chk("burst_full_seen", seen_full === 1'b1);
      n = 0;
      for (int c = 0; c < 700; c++) begin
         cyc(1);
         if (rx_valid_o && !rd_i) begin
            if (n < 8) begin
               got[n] = rx_data_o;
               t_arr[n] = c;
            end
            n++;
            rd_i = 1'b1;
         end else begin
            rd_i = 1'b0;
         end
      end
      rd_i = 1'b0;
      chk("burst_count", n === 5);
      for (int i = 0; i < 5; i++) chk($sformatf("burst_byte%0d", i), got[i] === (8'h10 + 8'(i)));
      for (int i = 1; i < 5; i++) chk($sformatf("burst_gap%0d", i), (t_arr[i] - t_arr[i-1]) === 100);
      chk("burst_ov", ov === 1'b0);
      chk("burst_busy", busy_o === 1'b0);
      loop_en = 1'b0;

      rx_drv = 1'b0; cyc(3); rx_drv = 1'b1;
      cyc(30);
      chk("glitch_valid", rx_valid_o === 1'b0);
      chk("glitch_fe", fe === 1'b0);

      loop_en = 1'b1;
      wr_i = 1'b1; tx_data_i = 8'h00; cyc(1);
      cyc(1); wr_i = 1'b0;
      cyc(40);
      chk("mid_tx_low", tx_o === 1'b0);
      chk("mid_busy", busy_o === 1'b1);
      rx_drv = 1'b0;
      reset_ni = 1'b0;
      loop_en = 1'b0;
      #1;
      chk("arst_tx", tx_o === 1'b1);
      chk("arst_busy", busy_o === 1'b0);
      chk("arst_valid", rx_valid_o === 1'b0);
      chk("arst_level", rx_level_o === 3'd0);
      chk("arst_full", tx_full_o === 1'b0);
      cyc(2);
      reset_ni = 1'b1;
      cyc(40);
      rx_drv = 1'b1;
      cyc(120);
      chk("post_rst_fe", fe === 1'b0);
      chk("post_rst_valid", rx_valid_o === 1'b0);
      chk("post_rst_busy", busy_o === 1'b0);
      chk("post_rst_tx", tx_o === 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
